// File: rtl/irq_commit.sv
// Trap/interrupt commit unit: arbitrates masked interrupt lines and ecall/ebreak/mret,
// sequences the mepc/mcause/mstatus writes and issues a one-cycle redirect to execute.
module irq_commit #(
  parameter int NUM_IRQ  = 8,
  parameter bit VECTORED = 1'b1,
  parameter bit IRQ_SYNC = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] csr_mie_i,
  input  logic               global_int_en_i,
  input  logic [31:0]        csr_mtvec_i,
  input  logic [31:0]        csr_mepc_i,
  input  logic [31:0]        csr_mstatus_i,
  input  logic [31:0]        inst_i,
  input  logic [31:0]        inst_addr_i,
  input  logic               jump_en_i,
  input  logic [31:0]        jump_addr_i,
  output logic               hold_o,
  output logic               csr_we_o,
  output logic [31:0]        csr_waddr_o,
  output logic [31:0]        csr_wdata_o,
  output logic               int_assert_o,
  output logic [31:0]        int_addr_o,
  output logic [3:0]         irq_id_o,
  output logic               busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_MEPC, S_W_MCAUSE, S_W_MSTATUS, S_ASSERT, S_MRET_ST, S_MRET_ASSERT
  } state_t;

  state_t             state, state_next;
  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] pending;
  logic [3:0]         irq_sel;
  logic               irq_any;
  logic               take_trap, take_mret, take;
  logic [31:0]        trap_cause;
  logic [31:0]        ret_pc;
  logic [31:0]        cause_r, pc_r;
  logic [3:0]         irq_id_r;
  logic               busy_r;
  logic [31:0]        vec_base;
  logic [31:0]        trap_mstatus, mret_mstatus;

  generate
    if (IRQ_SYNC) begin : g_sync
      logic [NUM_IRQ-1:0] sync1, sync2;
      always_ff @(posedge clk) begin
        if (rst) begin
          sync1 <= '0;
          sync2 <= '0;
        end else begin
          sync1 <= irq_i;
          sync2 <= sync1;
        end
      end
      assign irq_s = sync2;
    end else begin : g_nosync
      assign irq_s = irq_i;
    end
  endgenerate

  assign pending = irq_s & csr_mie_i & {NUM_IRQ{global_int_en_i}};
  assign irq_any = |pending;
  assign ret_pc  = jump_en_i ? jump_addr_i : inst_addr_i;

  // Lowest pending index wins: scan downward so the last hit is the lowest.
  always_comb begin
    irq_sel = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) irq_sel = 4'(i);
    end
  end

  always_comb begin
    take_trap  = 1'b0;
    take_mret  = 1'b0;
    trap_cause = 32'd0;
    if (inst_i == 32'h0000_0073) begin
      take_trap  = 1'b1;
      trap_cause = 32'd11;
    end else if (inst_i == 32'h0010_0073) begin
      take_trap  = 1'b1;
      trap_cause = 32'd3;
    end else if (inst_i == 32'h3020_0073) begin
      take_mret  = 1'b1;
    end else if (irq_any) begin
      take_trap  = 1'b1;
      trap_cause = 32'h8000_0000 | (32'd16 + 32'(irq_sel));
    end else begin
      take_trap  = 1'b0;
    end
  end

  assign take = (state == S_IDLE) && (take_trap || take_mret);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (take_trap)      state_next = S_W_MEPC;
        else if (take_mret) state_next = S_MRET_ST;
        else                state_next = S_IDLE;
      end
      S_W_MEPC:      state_next = S_W_MCAUSE;
      S_W_MCAUSE:    state_next = S_W_MSTATUS;
      S_W_MSTATUS:   state_next = S_ASSERT;
      S_ASSERT:      state_next = S_IDLE;
      S_MRET_ST:     state_next = S_MRET_ASSERT;
      S_MRET_ASSERT: state_next = S_IDLE;
      default:       state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy_r   <= 1'b0;
      cause_r  <= 32'd0;
      pc_r     <= 32'd0;
      irq_id_r <= 4'd0;
    end else begin
      state  <= state_next;
      busy_r <= (state_next != S_IDLE);
      if (state == S_IDLE && take_trap) begin
        cause_r <= trap_cause;
        pc_r    <= ret_pc;
        if (trap_cause[31]) irq_id_r <= irq_sel;
      end
    end
  end

  // Trap entry stashes MIE into MPIE and clears MIE; mret restores MIE and sets MPIE.
  assign trap_mstatus = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4], 1'b0,
                         csr_mstatus_i[2:0]};
  assign mret_mstatus = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4], csr_mstatus_i[7],
                         csr_mstatus_i[2:0]};
  assign vec_base     = {csr_mtvec_i[31:2], 2'b00};

  always_comb begin
    csr_we_o     = 1'b0;
    csr_waddr_o  = 32'd0;
    csr_wdata_o  = 32'd0;
    int_assert_o = 1'b0;
    int_addr_o   = 32'd0;
    case (state)
      S_W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = 32'h0000_0341;
        csr_wdata_o = pc_r;
      end
      S_W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = 32'h0000_0342;
        csr_wdata_o = cause_r;
      end
      S_W_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = 32'h0000_0300;
        csr_wdata_o = trap_mstatus;
      end
      S_ASSERT: begin
        int_assert_o = 1'b1;
        if (VECTORED && csr_mtvec_i[1:0] == 2'b01 && cause_r[31])
          int_addr_o = vec_base + {25'd0, cause_r[4:0], 2'b00};
        else
          int_addr_o = vec_base;
      end
      S_MRET_ST: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = 32'h0000_0300;
        csr_wdata_o = mret_mstatus;
      end
      S_MRET_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr_mepc_i;
      end
      default: begin
        csr_we_o = 1'b0;
      end
    endcase
  end

  assign hold_o   = take | busy_r;
  assign busy_o   = busy_r;
  assign irq_id_o = irq_id_r;

endmodule

// File: tb/tb_irq_commit.sv
// Directed bench for irq_commit (NUM_IRQ=8, VECTORED=1, IRQ_SYNC=0).
module tb_irq_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq, mie;
  logic        gie;
  logic [31:0] mtvec, mepc, mstatus, inst, inst_addr, jump_addr;
  logic        jump_en;
  logic        hold, csr_we, int_assert, busy;
  logic [31:0] csr_waddr, csr_wdata, int_addr;
  logic [3:0]  irq_id;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] EBRK  = 32'h0010_0073;
  localparam logic [31:0] MRET  = 32'h3020_0073;

  irq_commit #(.NUM_IRQ(8), .VECTORED(1'b1), .IRQ_SYNC(1'b0)) dut (
    .clk(clk), .rst(rst), .irq_i(irq), .csr_mie_i(mie), .global_int_en_i(gie),
    .csr_mtvec_i(mtvec), .csr_mepc_i(mepc), .csr_mstatus_i(mstatus),
    .inst_i(inst), .inst_addr_i(inst_addr), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .hold_o(hold), .csr_we_o(csr_we), .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata),
    .int_assert_o(int_assert), .int_addr_o(int_addr), .irq_id_o(irq_id), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " hold"}, {31'd0, hold}, 32'd0);
    chk({tag, " we"}, {31'd0, csr_we}, 32'd0);
    chk({tag, " waddr"}, csr_waddr, 32'd0);
    chk({tag, " wdata"}, csr_wdata, 32'd0);
    chk({tag, " assert"}, {31'd0, int_assert}, 32'd0);
    chk({tag, " addr"}, int_addr, 32'd0);
    chk({tag, " irq_id"}, {28'd0, irq_id}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Called in the decision cycle T; walks T+1..T+5 clearing one-shot stimulus.
  task automatic trap_seq(input string tag, input logic [31:0] pc, input logic [31:0] cause,
                          input logic [31:0] mst, input logic [31:0] vec);
    #1;
    chk({tag, " T hold"}, {31'd0, hold}, 32'd1);
    chk({tag, " T busy"}, {31'd0, busy}, 32'd0);
    adv();
    irq = 8'h00; inst = NOP; jump_en = 1'b0;
    #1;
    chk({tag, " mepc we"}, {31'd0, csr_we}, 32'd1);
    chk({tag, " mepc addr"}, csr_waddr, 32'h341);
    chk({tag, " mepc data"}, csr_wdata, pc);
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    adv(); #1;
    chk({tag, " mcause addr"}, csr_waddr, 32'h342);
    chk({tag, " mcause data"}, csr_wdata, cause);
    adv(); #1;
    chk({tag, " mstatus addr"}, csr_waddr, 32'h300);
    chk({tag, " mstatus data"}, csr_wdata, mst);
    adv(); #1;
    chk({tag, " assert"}, {31'd0, int_assert}, 32'd1);
    chk({tag, " vec"}, int_addr, vec);
    chk({tag, " assert we"}, {31'd0, csr_we}, 32'd0);
    chk({tag, " assert hold"}, {31'd0, hold}, 32'd1);
    adv(); #1;
    chk({tag, " done hold"}, {31'd0, hold}, 32'd0);
    chk({tag, " done assert"}, {31'd0, int_assert}, 32'd0);
    chk({tag, " done busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; irq = 8'h00; mie = 8'hFF; gie = 1'b1; mtvec = 32'h100; mepc = 32'h0;
    mstatus = 32'h08; inst = NOP; inst_addr = 32'h0; jump_en = 1'b0; jump_addr = 32'h0;
    adv(); adv();
    #1;
    all_zero("reset");
    rst = 1'b0;

    // Direct interrupt: lines 2 and 5 high, lowest index wins
    adv();
    irq = 8'h24; inst_addr = 32'h40;
    trap_seq("direct", 32'h40, 32'h8000_0012, 32'h80, 32'h100);
    chk("direct irq_id", {28'd0, irq_id}, 32'd2);

    // Vectored interrupt on channel 5
    adv();
    mtvec = 32'h201; irq = 8'h20; inst_addr = 32'h48;
    trap_seq("vectored", 32'h48, 32'h8000_0015, 32'h80, 32'h254);
    chk("vectored irq_id", {28'd0, irq_id}, 32'd5);

    // ecall with vectored mtvec still dispatches to the base
    adv();
    inst = ECALL; inst_addr = 32'h50;
    trap_seq("ecall_vec", 32'h50, 32'd11, 32'h80, 32'h200);

    // Masking: global enable off, then per-channel mask off
    adv();
    gie = 1'b0; irq = 8'hFF;
    #1;
    chk("mask gie hold", {31'd0, hold}, 32'd0);
    adv(); #1;
    chk("mask gie we", {31'd0, csr_we}, 32'd0);
    chk("mask gie busy", {31'd0, busy}, 32'd0);
    gie = 1'b1; mie = 8'h00; irq = 8'h01;
    adv(); #1;
    chk("mask mie hold", {31'd0, hold}, 32'd0);
    adv(); #1;
    chk("mask mie we", {31'd0, csr_we}, 32'd0);
    gie = 1'b0; inst = ECALL; inst_addr = 32'h80;
    trap_seq("ecall_masked", 32'h80, 32'd11, 32'h80, 32'h200);

    // ebreak beats an enabled pending line
    adv();
    gie = 1'b1; mie = 8'hFF; irq = 8'h08; inst = EBRK; inst_addr = 32'h90;
    trap_seq("ebreak", 32'h90, 32'd3, 32'h80, 32'h200);

    // ecall + irq + jump: ecall wins, return PC from execute
    adv();
    mtvec = 32'h100; irq = 8'h01; inst = ECALL; inst_addr = 32'h60;
    jump_en = 1'b1; jump_addr = 32'h300;
    trap_seq("simul", 32'h300, 32'd11, 32'h80, 32'h100);

    // mret
    adv();
    mstatus = 32'h80; mepc = 32'h44; inst = MRET;
    #1;
    chk("mret T hold", {31'd0, hold}, 32'd1);
    adv();
    inst = NOP;
    #1;
    chk("mret we", {31'd0, csr_we}, 32'd1);
    chk("mret waddr", csr_waddr, 32'h300);
    chk("mret wdata", csr_wdata, 32'h88);
    adv(); #1;
    chk("mret assert", {31'd0, int_assert}, 32'd1);
    chk("mret addr", int_addr, 32'h44);
    chk("mret assert we", {31'd0, csr_we}, 32'd0);
    adv(); #1;
    chk("mret done hold", {31'd0, hold}, 32'd0);
    chk("mret done assert", {31'd0, int_assert}, 32'd0);

    // Reset in W_MCAUSE aborts the sequence
    adv();
    mstatus = 32'h08; irq = 8'h02; inst_addr = 32'hA0;
    adv();
    irq = 8'h00;
    #1;
    chk("rst mepc addr", csr_waddr, 32'h341);
    adv(); #1;
    chk("rst mcause addr", csr_waddr, 32'h342);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    #1;
    all_zero("rst mid");
    adv(); #1;
    chk("rst no mstatus we", {31'd0, csr_we}, 32'd0);
    chk("rst no mstatus addr", csr_waddr, 32'd0);
    chk("rst idle busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
